// File: rtl/freecell_engine.sv
// freecell_engine: FreeCell game-state engine.
// Holds the tableau, free cells and home foundations, takes an initial deal
// through the load port, then checks and executes one single-card move per
// handshake. Results, the move count and the win flag are registered.
module freecell_engine #(
    parameter int NCOLS = 8,
    parameter int NFREE = 4,
    parameter int DEPTH = 20,
    parameter int MCW   = 16,
    parameter int CW    = (NCOLS > 1) ? $clog2(NCOLS) : 1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           load_valid,
    input  logic [CW-1:0]  load_col,
    input  logic [5:0]     load_card,
    output logic           load_err,
    input  logic           start,
    input  logic           move_valid,
    input  logic [3:0]     move_src,
    input  logic [3:0]     move_dst,
    output logic           move_ready,
    output logic           move_done,
    output logic           move_ok,
    output logic [MCW-1:0] moves,
    output logic           win
);

    localparam int HW = $clog2(DEPTH + 1);
    localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = (NFREE > 1) ? $clog2(NFREE) : 1;

    localparam logic [3:0]    SEL_CELL = 4'(NCOLS);
    localparam logic [3:0]    SEL_END  = 4'(NCOLS + NFREE);
    localparam logic [3:0]    SEL_HOME = 4'd15;
    localparam logic [HW-1:0] FULL     = HW'(DEPTH);

    typedef enum logic [1:0] {ST_LOAD, ST_PLAY, ST_WON} state_t;

    state_t         state_q;
    logic [HW-1:0]  height_q [NCOLS];
    logic [5:0]     cell_q   [NFREE];
    logic [3:0]     home_q   [4];
    logic [3:0]     home_d   [4];
    logic [5:0]     col_mem  [NCOLS][DEPTH];
    logic [MCW-1:0] moves_q;
    logic           load_err_q, done_q, ok_q, win_q;

    // Card colour: diamonds and hearts (suits 1, 2) are red.
    function automatic logic is_red(input logic [5:0] c);
        return c[5] ^ c[4];
    endfunction

    // Storage index of the top card of a non-empty column.
    function automatic logic [DW-1:0] top_idx(input logic [HW-1:0] h);
        return DW'(h - 1'b1);
    endfunction

    // Selector decode
    logic          src_col, src_cell, dst_col, dst_cell, dst_home;
    logic [CW-1:0] sc, dc;
    logic [FW-1:0] sf, df;

    assign src_col  = (move_src < SEL_CELL);
    assign src_cell = (move_src >= SEL_CELL) && (move_src < SEL_END);
    assign dst_col  = (move_dst < SEL_CELL);
    assign dst_cell = (move_dst >= SEL_CELL) && (move_dst < SEL_END);
    assign dst_home = (move_dst == SEL_HOME);
    assign sc       = move_src[CW-1:0];
    assign dc       = move_dst[CW-1:0];
    assign sf       = FW'(move_src - SEL_CELL);
    assign df       = FW'(move_dst - SEL_CELL);

    logic       accept, legal, dst_fits, all_home;
    logic [5:0] src_card, dst_top;
    logic       load_col_ok, load_ok, load_push;

    assign accept = move_valid && (state_q == ST_PLAY);

    // Legality of the presented move against the current game state.
    always_comb begin
        src_card = '0;
        if (src_col && height_q[sc] != '0)
            src_card = col_mem[sc][top_idx(height_q[sc])];
        else if (src_cell)
            src_card = cell_q[sf];

        dst_top = '0;
        if (dst_col && height_q[dc] != '0)
            dst_top = col_mem[dc][top_idx(height_q[dc])];

        dst_fits = 1'b0;
        if (dst_col)
            dst_fits = (height_q[dc] != FULL) &&
                       ((height_q[dc] == '0) ||
                        ((is_red(dst_top) != is_red(src_card)) &&
                         (dst_top[3:0] == src_card[3:0] + 4'd1)));
        else if (dst_cell)
            dst_fits = (cell_q[df] == '0);
        else if (dst_home)
            dst_fits = (src_card[3:0] == home_q[src_card[5:4]] + 4'd1);

        legal = (src_col || src_cell) && (src_card[3:0] != '0) &&
                dst_fits && (move_src != move_dst);
    end

    // Foundation state after this cycle's move, used for the win decision.
    always_comb begin
        home_d = home_q;
        if (accept && legal && dst_home)
            home_d[src_card[5:4]] = src_card[3:0];
        all_home = 1'b1;
        for (int s = 0; s < 4; s++)
            if (home_d[s] != 4'd13) all_home = 1'b0;
    end

    // Deal-time push check: valid column, room left, rank 1..13.
    always_comb begin
        load_col_ok = ({1'b0, load_col} < (CW+1)'(NCOLS));
        load_ok     = load_col_ok && (height_q[load_col] != FULL) &&
                      (load_card[3:0] != 4'd0) && (load_card[3:0] <= 4'd13);
        load_push   = (state_q == ST_LOAD) && load_valid && load_ok;
    end

    // Game control state, column heights, cells, homes and registered results.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_LOAD;
            moves_q    <= '0;
            load_err_q <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            win_q      <= 1'b0;
            for (int i = 0; i < NCOLS; i++) height_q[i] <= '0;
            for (int i = 0; i < NFREE; i++) cell_q[i]   <= '0;
            for (int i = 0; i < 4; i++)     home_q[i]   <= '0;
        end else begin
            load_err_q <= (state_q == ST_LOAD) && load_valid && !load_ok;
            done_q     <= accept;
            ok_q       <= accept && legal;
            home_q     <= home_d;

            if (load_push)
                height_q[load_col] <= height_q[load_col] + 1'b1;
            if (state_q == ST_LOAD && start)
                state_q <= ST_PLAY;

            if (accept && legal) begin
                if (src_col)  height_q[sc] <= height_q[sc] - 1'b1;
                if (src_cell) cell_q[sf]   <= '0;
                if (dst_col)  height_q[dc] <= height_q[dc] + 1'b1;
                if (dst_cell) cell_q[df]   <= src_card;
                if (moves_q != '1) moves_q <= moves_q + 1'b1;
                if (all_home) begin
                    state_q <= ST_WON;
                    win_q   <= 1'b1;
                end
            end
        end
    end

    // Card storage; validity is defined by the column heights alone.
    always_ff @(posedge clock) begin
        if (load_push)
            col_mem[load_col][DW'(height_q[load_col])] <= load_card;
        if (accept && legal && dst_col)
            col_mem[dc][DW'(height_q[dc])] <= src_card;
    end

    assign move_ready = (state_q == ST_PLAY);
    assign move_done  = done_q;
    assign move_ok    = ok_q;
    assign moves      = moves_q;
    assign win        = win_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_freecell_engine.sv
// Bench for freecell_engine: directed deals and moves, with a game model
// (card arrays per column, cells, homes) checked every cycle plus literal pins.
module tb_freecell_engine;

    localparam int NCOLS = 8;
    localparam int NFREE = 4;
    localparam int DEPTH = 20;
    localparam int MCW   = 16;
    localparam int CW    = 3;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           load_valid = 1'b0;
    logic [CW-1:0]  load_col = '0;
    logic [5:0]     load_card = '0;
    logic           start = 1'b0;
    logic           move_valid = 1'b0;
    logic [3:0]     move_src = '0;
    logic [3:0]     move_dst = '0;
    logic           load_err, move_ready, move_done, move_ok, win;
    logic [MCW-1:0] moves;

    freecell_engine #(.NCOLS(NCOLS), .NFREE(NFREE), .DEPTH(DEPTH), .MCW(MCW), .CW(CW)) dut (
        .clock(clock), .reset_n(reset_n),
        .load_valid(load_valid), .load_col(load_col), .load_card(load_card),
        .load_err(load_err), .start(start),
        .move_valid(move_valid), .move_src(move_src), .move_dst(move_dst),
        .move_ready(move_ready), .move_done(move_done), .move_ok(move_ok),
        .moves(moves), .win(win)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- game model ----------------
    int         m_state;          // 0 deal, 1 play, 2 won
    int         m_h[NCOLS];
    logic [5:0] m_c[NCOLS][32];
    logic [5:0] m_cell[NFREE];
    int         m_home[4];
    int         exp_moves;
    bit         exp_err, exp_done, exp_ok, exp_ready, exp_win;

    function automatic bit red(input logic [5:0] c);
        return c[5] ^ c[4];
    endfunction

    // 0 column, 1 free cell, 2 home, 3 unused code
    function automatic int kind(input int code);
        if (code < NCOLS) return 0;
        if (code < NCOLS + NFREE) return 1;
        if (code == 15) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_state = 0;
        for (int i = 0; i < NCOLS; i++) m_h[i] = 0;
        for (int i = 0; i < NFREE; i++) m_cell[i] = '0;
        for (int i = 0; i < 4; i++) m_home[i] = 0;
        exp_moves = 0;
        exp_err = 0; exp_done = 0; exp_ok = 0; exp_ready = 0; exp_win = 0;
    endtask

    task automatic try_move(input int s, input int d, output bit ok);
        int sk, dk, r, su;
        logic [5:0] card, top;
        ok = 0;
        sk = kind(s);
        dk = kind(d);
        if (s == d || sk >= 2 || dk == 3) return;
        if (sk == 0) card = (m_h[s] > 0) ? m_c[s][m_h[s]-1] : 6'h00;
        else         card = m_cell[s-NCOLS];
        if (card[3:0] == 0) return;
        r  = int'(card[3:0]);
        su = int'(card[5:4]);
        if (dk == 0) begin
            if (m_h[d] >= DEPTH) return;
            if (m_h[d] > 0) begin
                top = m_c[d][m_h[d]-1];
                if (red(top) == red(card) || int'(top[3:0]) != r + 1) return;
            end
        end else if (dk == 1) begin
            if (m_cell[d-NCOLS] != 0) return;
        end else begin
            if (m_home[su] + 1 != r) return;
        end
        if (sk == 0) m_h[s]--; else m_cell[s-NCOLS] = '0;
        if (dk == 0) begin m_c[d][m_h[d]] = card; m_h[d]++; end
        else if (dk == 1) m_cell[d-NCOLS] = card;
        else m_home[su] = r;
        ok = 1;
    endtask

    task automatic model_step();
        bit ok;
        int c, r;
        exp_err = 0; exp_done = 0; exp_ok = 0;
        if (m_state == 0) begin
            if (load_valid) begin
                c = int'(load_col);
                r = int'(load_card[3:0]);
                if (c >= NCOLS || m_h[c] >= DEPTH || r < 1 || r > 13) exp_err = 1;
                else begin m_c[c][m_h[c]] = load_card; m_h[c]++; end
            end
            if (start) m_state = 1;
        end else if (m_state == 1 && move_valid) begin
            exp_done = 1;
            try_move(int'(move_src), int'(move_dst), ok);
            exp_ok = ok;
            if (ok && exp_moves < (1 << MCW) - 1) exp_moves++;
            if (m_home[0] == 13 && m_home[1] == 13 && m_home[2] == 13 && m_home[3] == 13)
                m_state = 2;
        end
        exp_ready = (m_state == 1);
        exp_win   = (m_state == 2);
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en && reset_n) begin
            check("load_err", load_err, exp_err);
            check("move_done", move_done, exp_done);
            if (exp_done) check("move_ok", move_ok, exp_ok);
            check("moves", moves, exp_moves);
            check("win", win, exp_win);
            check("move_ready", move_ready, exp_ready);
        end
    end

    // ---------------- stimulus ----------------
    task automatic load(input int c, input logic [5:0] card, input bit st = 1'b0);
        @(negedge clock);
        load_valid = 1'b1; load_col = CW'(c); load_card = card; start = st;
        @(negedge clock);
        load_valid = 1'b0; start = 1'b0;
    endtask

    task automatic go();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic mv(input int s, input int d);
        @(negedge clock);
        move_valid = 1'b1; move_src = 4'(s); move_dst = 4'(d);
        @(negedge clock);
        move_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock); reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #1;
        check("rst_ready", move_ready, 0);
        check("rst_moves", moves, 0);
        check("rst_win", win, 0);
        check("rst_done", move_done, 0);
        @(negedge clock);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Column capacity and load errors
        for (int i = 0; i < 20; i++)
            load(0, (i >= 18) ? 6'h25 : {2'd0, 4'(i % 13 + 1)});
        load(0, 6'h33);
        check("load21_err", load_err, 1);
        check("model_col0_h", m_h[0], 20);
        load(2, 6'h30);
        check("rank0_err", load_err, 1);
        load(2, 6'h3E);
        check("rank14_err", load_err, 1);
        load(1, 6'h04);
        check("good_load_err", load_err, 0);
        go();
        mv(1, 0);
        check("full_dst_ok", move_ok, 0);
        mv(0, 8);
        check("col_to_cell_ok", move_ok, 1);
        mv(1, 0);
        check("onto_red5_ok", move_ok, 1);
        check("moves_after_A", moves, 2);
        mv(2, 9);
        check("empty_src_ok", move_ok, 0);

        // Move rules
        do_reset();
        load(0, 6'h14); load(0, 6'h25); load(1, 6'h36); load(2, 6'h01);
        load(3, 6'h07); load(4, 6'h04); load(6, 6'h12);
        go();
        mv(0, 1);
        check("5H_on_6S_done", move_done, 1);
        check("5H_on_6S_ok", move_ok, 1);
        check("5H_on_6S_moves", moves, 1);
        mv(0, 1);
        check("4D_on_5H_ok", move_ok, 0);
        mv(2, 8);
        check("ace_to_cell_ok", move_ok, 1);
        mv(3, 8);
        check("occupied_cell_ok", move_ok, 0);
        mv(8, 15);
        check("ace_home_ok", move_ok, 1);
        check("model_home_clubs", m_home[0], 1);
        mv(3, 15);
        check("7C_home_ok", move_ok, 0);
        mv(15, 0);
        check("src_home_ok", move_ok, 0);
        mv(3, 3);
        check("src_eq_dst_ok", move_ok, 0);
        mv(3, 13);
        check("dst13_ok", move_ok, 0);
        mv(3, 12);
        check("dst12_ok", move_ok, 0);
        check("moves_unchanged", moves, 3);
        mv(6, 1);
        check("2D_on_5H_ok", move_ok, 0);
        mv(4, 1);
        check("4C_on_5H_ok", move_ok, 1);
        mv(6, 1);
        check("2D_on_4C_ok", move_ok, 0);
        mv(8, 0);
        check("empty_cell_src_ok", move_ok, 0);
        load(7, 6'h01);
        mv(7, 9);
        check("play_load_ignored", move_ok, 0);
        mv(3, 9);
        mv(0, 5);
        check("to_empty_col_ok", move_ok, 1);

        // Reset while a legal move is in flight
        @(negedge clock);
        move_valid = 1'b1; move_src = 4'd6; move_dst = 4'd10;
        @(posedge clock);
        #2 reset_n = 1'b0;
        move_valid = 1'b0;
        #1;
        check("midrst_done", move_done, 0);
        check("midrst_ok", move_ok, 0);
        check("midrst_moves", moves, 0);
        check("midrst_ready", move_ready, 0);
        check("midrst_win", win, 0);
        @(negedge clock);
        reset_n = 1'b1;
        mv(0, 8);
        check("load_state_no_move", move_done, 0);
        load(0, 6'h01); load(1, 6'h01);
        go();
        mv(0, 9);
        check("cell_cleared_ok", move_ok, 1);
        mv(1, 15);
        check("home_cleared_ok", move_ok, 1);

        // Full game: four suits K..A, start with the last card
        do_reset();
        for (int s = 0; s < 4; s++)
            for (int r = 13; r >= 1; r--)
                load(s, {2'(s), 4'(r)}, (s == 3 && r == 1));
        for (int r = 1; r <= 13; r++)
            for (int s = 0; s < 4; s++) begin
                @(negedge clock);
                move_valid = 1'b1; move_src = 4'(s); move_dst = 4'd15;
            end
        @(negedge clock);
        move_valid = 1'b0;
        check("win_final", win, 1);
        check("moves_final", moves, 52);
        check("ready_after_win", move_ready, 0);
        mv(0, 15);
        check("move53_done", move_done, 0);
        check("win_holds", win, 1);
        repeat (2) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
